de_md_issue_reg: RTL

- D/E pipeline register for the P6 five-stage MIPS core, with the mult/div structural-hazard interlock built in.
- Feeds the E-stage HI/LO multiply-divide unit: E-stage instruction word plus operands A (rs value) and B (rt value).
- Consumes the unit's busy output.
- Holds D and inserts an E-stage bubble while a multiply/divide is in flight and D carries any HI/LO-class instruction.
- Also ORs in the general hazard unit's stall and counts stall cycles for performance debug.

---
 rtl/de_md_issue_reg_if.sv | 29 ++
 rtl/de_md_issue_reg.sv | 77 +++++++
 2 files changed

// File: rtl/de_md_issue_reg_if.sv
// rtl/de_md_issue_reg_if.sv - D/E issue register bus between decode and the E stage
interface de_md_issue_reg_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr_d;
    logic [31:0]      pc_d;
    logic [31:0]      rs_val_d;
    logic [31:0]      rt_val_d;
    logic             stall_other;
    logic             md_busy_e;
    logic [31:0]      instr_e;
    logic [31:0]      pc_e;
    logic [31:0]      a_e;
    logic [31:0]      b_e;
    logic             md_start_e;
    logic             stall_d;
    logic             md_stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output instr_d, pc_d, rs_val_d, rt_val_d, stall_other, md_busy_e,
        input  instr_e, pc_e, a_e, b_e, md_start_e, stall_d, md_stall, stall_cnt
    );

    modport slave (
        input  instr_d, pc_d, rs_val_d, rt_val_d, stall_other, md_busy_e,
        output instr_e, pc_e, a_e, b_e, md_start_e, stall_d, md_stall, stall_cnt
    );
endinterface

// File: rtl/de_md_issue_reg.sv
// rtl/de_md_issue_reg.sv - D/E pipeline register with mult/div interlock and stall counter
module de_md_issue_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    de_md_issue_reg_if.slave   bus
);

    function automatic logic is_md_class(input logic [31:0] w);
        return (w[31:26] == 6'b000000) &&
               (w[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic logic is_md_start(input logic [31:0] w);
        return (w[31:26] == 6'b000000) &&
               (w[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_start;
    logic             md_stall;
    logic             stall;

    // md_start covers the cycle a start op sits in E before the unit raises busy
    always_comb begin
        md_start = is_md_start(instr_q);
        md_stall = is_md_class(bus.instr_d) & (bus.md_busy_e | md_start);
        stall    = md_stall | bus.stall_other;

        instr_d = bus.instr_d;
        pc_d    = bus.pc_d;
        a_d     = bus.rs_val_d;
        b_d     = bus.rt_val_d;
        cnt_d   = cnt_q;

        if (stall) begin
            instr_d = 32'h0000_0000;
            a_d     = 32'h0000_0000;
            b_d     = 32'h0000_0000;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= 32'h0000_0000;
            pc_q    <= RESET_PC;
            a_q     <= 32'h0000_0000;
            b_q     <= 32'h0000_0000;
            cnt_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.instr_e    = instr_q;
    assign bus.pc_e       = pc_q;
    assign bus.a_e        = a_q;
    assign bus.b_e        = b_q;
    assign bus.md_start_e = md_start;
    assign bus.md_stall   = md_stall;
    assign bus.stall_d    = stall;
    assign bus.stall_cnt  = cnt_q;

endmodule
